// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst/response types and constants, the
// beat_addr helper, and the channel/request/response structs for the
// default axi_mem_slv widths (64-bit address, 128-bit data, 6-bit ID,
// 2-bit user). The struct layout follows the axi/typedef.svh macros.
package axi_pkg;

  typedef logic [1:0] burst_t;
  typedef logic [1:0] resp_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // Byte address of beat 'beat' of a burst starting at 'addr'. FIXED keeps
  // the start address; every other burst type steps by the beat size.
  function automatic logic [63:0] beat_addr(input logic [63:0] addr,
                                            input logic [2:0]  size,
                                            input burst_t      burst,
                                            input logic [7:0]  beat);
    if (burst == BURST_FIXED) return addr;
    return addr + (64'(beat) << size);
  endfunction

  typedef struct packed {
    logic [5:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    burst_t      burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [1:0]  user;
  } aw_chan_t;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  strb;
    logic         last;
    logic [1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [5:0] id;
    resp_t      resp;
    logic [1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [5:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    burst_t      burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [1:0]  user;
  } ar_chan_t;

  typedef struct packed {
    logic [5:0]   id;
    logic [127:0] data;
    resp_t        resp;
    logic         last;
    logic [1:0]   user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } mem_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } mem_rsp_t;

endpackage

// File: rtl/axi_mem_slv_addr_gen.sv
// Burst address tracker for one AXI direction.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   load_i             address handshake: latch addr/len/size/burst, clear counter
//   addr_i, len_i,
//   size_i, burst_i    burst description from the AW or AR channel
//   next_i             data beat accepted: advance address and counter
//   idx_o              word index of the current beat
//   last_o             current beat is beat 'len'
//   oob_o              some beat of the latched burst falls outside the array
//   burst_o            latched burst type
module axi_mem_slv_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned NumWords  = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        load_i,
  input  logic [AddrWidth-1:0]        addr_i,
  input  logic [7:0]                  len_i,
  input  logic [2:0]                  size_i,
  input  burst_t                      burst_i,
  input  logic                        next_i,
  output logic [$clog2(NumWords)-1:0] idx_o,
  output logic                        last_o,
  output logic                        oob_o,
  output burst_t                      burst_o
);

  localparam int unsigned OffW = $clog2(DataWidth / 8);
  localparam int unsigned IdxW = $clog2(NumWords);

  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           len_q;
  logic [2:0]           size_q;
  burst_t               burst_q;
  logic [7:0]           cnt_q;
  logic                 oob_q;

  function automatic logic out_of_range(input logic [AddrWidth-1:0] a);
    return |(a >> (OffW + IdxW));
  endfunction

  // Addresses only move upward within a burst, so checking the first and
  // the final beat covers every beat in between.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BURST_FIXED;
      cnt_q   <= '0;
      oob_q   <= 1'b0;
    end else if (load_i) begin
      addr_q  <= addr_i;
      len_q   <= len_i;
      size_q  <= size_i;
      burst_q <= burst_i;
      cnt_q   <= '0;
      oob_q   <= out_of_range(addr_i) |
                 out_of_range(AddrWidth'(beat_addr(64'(addr_i), size_i, burst_i, len_i)));
    end else if (next_i) begin
      if (burst_q == BURST_INCR) addr_q <= addr_q + (AddrWidth'(1) << size_q);
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign idx_o   = addr_q[OffW +: IdxW];
  assign last_o  = (cnt_q == len_q);
  assign oob_o   = oob_q;
  assign burst_o = burst_q;

endmodule

// File: rtl/axi_mem_slv.sv
// AXI4 memory responder over a word array; one outstanding write and one
// outstanding read, INCR and FIXED bursts, SLVERR for WRAP or out-of-range.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   axi_req_i  AW/W/AR channels plus b_ready and r_ready
//   axi_rsp_o  aw/w/ar ready plus the B and R channels
module axi_mem_slv
  import axi_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned IdWidth   = 6,
  parameter int unsigned UserWidth = 2,
  parameter int unsigned NumWords  = 1024,
  parameter type         axi_req_t = axi_pkg::mem_req_t,
  parameter type         axi_rsp_t = axi_pkg::mem_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxW      = $clog2(NumWords);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  logic [IdxW-1:0] w_idx, r_idx;
  logic            w_last, r_last, w_oob, r_oob, w_err, r_err;
  burst_t          w_burst, r_burst;

  logic [IdWidth-1:0]   aw_id_q, ar_id_q;
  logic [UserWidth-1:0] aw_user_q, ar_user_q;
  logic                 wlast_err_q;

  logic [DataWidth-1:0] mem_q [NumWords];

  assign aw_hs = axi_req_i.aw_valid & aw_ready;
  assign w_hs  = axi_req_i.w_valid  & w_ready;
  assign b_hs  = axi_req_i.b_ready  & b_valid;
  assign ar_hs = axi_req_i.ar_valid & ar_ready;
  assign r_hs  = axi_req_i.r_ready  & r_valid;

  axi_mem_slv_addr_gen #(
    .AddrWidth(AddrWidth), .DataWidth(DataWidth), .NumWords(NumWords)
  ) i_aw_gen (
    .clk_i, .rst_ni,
    .load_i (aw_hs),
    .addr_i (axi_req_i.aw.addr),
    .len_i  (axi_req_i.aw.len),
    .size_i (axi_req_i.aw.size),
    .burst_i(axi_req_i.aw.burst),
    .next_i (w_hs),
    .idx_o  (w_idx),
    .last_o (w_last),
    .oob_o  (w_oob),
    .burst_o(w_burst)
  );

  axi_mem_slv_addr_gen #(
    .AddrWidth(AddrWidth), .DataWidth(DataWidth), .NumWords(NumWords)
  ) i_ar_gen (
    .clk_i, .rst_ni,
    .load_i (ar_hs),
    .addr_i (axi_req_i.ar.addr),
    .len_i  (axi_req_i.ar.len),
    .size_i (axi_req_i.ar.size),
    .burst_i(axi_req_i.ar.burst),
    .next_i (r_hs),
    .idx_o  (r_idx),
    .last_o (r_last),
    .oob_o  (r_oob),
    .burst_o(r_burst)
  );

  assign w_err = w_oob | (w_burst == BURST_WRAP);
  assign r_err = r_oob | (r_burst == BURST_WRAP);

  // Write FSM
  always_comb begin
    w_state_d = w_state_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready = 1'b1;
        if (axi_req_i.aw_valid) w_state_d = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        // The beat counter alone ends the burst; w_last is only checked.
        if (axi_req_i.w_valid && w_last) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (axi_req_i.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q   <= W_IDLE;
      aw_id_q     <= '0;
      aw_user_q   <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        aw_id_q     <= axi_req_i.aw.id;
        aw_user_q   <= axi_req_i.aw.user;
        wlast_err_q <= 1'b0;
      end else if (w_hs && (axi_req_i.w.last != w_last)) begin
        wlast_err_q <= 1'b1;
      end
    end
  end

  // Read FSM
  always_comb begin
    r_state_d = r_state_q;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (axi_req_i.ar_valid) r_state_d = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (axi_req_i.r_ready && r_last) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      ar_id_q   <= '0;
      ar_user_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        ar_id_q   <= axi_req_i.ar.id;
        ar_user_q <= axi_req_i.ar.user;
      end
    end
  end

  // Storage is deliberately not reset. An erroneous write burst is
  // dropped as a whole because its error flag is known from the AW beat.
  always_ff @(posedge clk_i) begin
    if (w_hs && !w_err) begin
      for (int lane = 0; lane < StrbWidth; lane++) begin
        if (axi_req_i.w.strb[lane]) mem_q[w_idx][8*lane +: 8] <= axi_req_i.w.data[8*lane +: 8];
      end
    end
  end

  // Read payload is gated with r_valid so it is zero outside a burst.
  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = aw_ready;
    axi_rsp_o.w_ready  = w_ready;
    axi_rsp_o.ar_ready = ar_ready;
    axi_rsp_o.b_valid  = b_valid;
    axi_rsp_o.b.id     = aw_id_q;
    axi_rsp_o.b.user   = aw_user_q;
    axi_rsp_o.b.resp   = (w_err || wlast_err_q) ? RESP_SLVERR : RESP_OKAY;
    axi_rsp_o.r_valid  = r_valid;
    axi_rsp_o.r.id     = ar_id_q;
    axi_rsp_o.r.user   = ar_user_q;
    axi_rsp_o.r.data   = (r_valid && !r_err) ? mem_q[r_idx] : '0;
    axi_rsp_o.r.resp   = (r_valid && r_err) ? RESP_SLVERR : RESP_OKAY;
    axi_rsp_o.r.last   = r_valid & r_last;
  end

  logic unused_fields;
  assign unused_fields = ^{axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot,
                           axi_req_i.aw.qos, axi_req_i.aw.region, axi_req_i.aw.atop,
                           axi_req_i.ar.lock, axi_req_i.ar.cache, axi_req_i.ar.prot,
                           axi_req_i.ar.qos, axi_req_i.ar.region, axi_req_i.w.user,
                           b_hs};

endmodule

// File: tb/tb_axi_mem_slv.sv
module tb_axi_mem_slv;
  import axi_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  mem_req_t req;
  mem_rsp_t rsp;

  aw_chan_t aw;
  w_chan_t  w;
  ar_chan_t ar;
  logic     aw_valid, w_valid, b_ready, ar_valid, r_ready;

  int checks   = 0;
  int failures = 0;

  logic [127:0] wd [8];
  logic [127:0] ed [8];
  logic [127:0] t1 [4];

  always #5 clk = ~clk;

  always_comb begin
    req          = '0;
    req.aw       = aw;
    req.aw_valid = aw_valid;
    req.w        = w;
    req.w_valid  = w_valid;
    req.b_ready  = b_ready;
    req.ar       = ar;
    req.ar_valid = ar_valid;
    req.r_ready  = r_ready;
  end

  axi_mem_slv #(
    .AddrWidth(64), .DataWidth(128), .IdWidth(6), .UserWidth(2), .NumWords(1024),
    .axi_req_t(mem_req_t), .axi_rsp_t(mem_rsp_t)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .axi_req_i(req),
    .axi_rsp_o(rsp)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return rsp.aw_ready;
      1:       return rsp.w_ready;
      2:       return rsp.ar_ready;
      3:       return rsp.b_valid;
      default: return rsp.r_valid;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input string tag);
    int n = 0;
    while (!pick(sel) && n < 64) begin
      tick();
      n++;
    end
    chk({tag, "_wait"}, 128'(pick(sel)), 128'(1));
  endtask

  task automatic send_aw(input logic [63:0] a, input logic [7:0] len, input burst_t bu,
                         input logic [5:0] id);
    aw = '0; aw.addr = a; aw.len = len; aw.size = 3'd4; aw.burst = bu; aw.id = id;
    aw.user = 2'd1;
    aw_valid = 1'b1;
    wait_sig(0, "aw_ready");
    tick();
    aw_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [63:0] a, input logic [7:0] len, input burst_t bu,
                         input logic [5:0] id);
    ar = '0; ar.addr = a; ar.len = len; ar.size = 3'd4; ar.burst = bu; ar.id = id;
    ar_valid = 1'b1;
    wait_sig(2, "ar_ready");
    tick();
    ar_valid = 1'b0;
  endtask

  task automatic send_w(input int nb, input int last_at, input logic [15:0] strb);
    for (int i = 0; i < nb; i++) begin
      w = '0; w.data = wd[i]; w.strb = strb; w.last = (i == last_at);
      w_valid = 1'b1;
      wait_sig(1, "w_ready");
      tick();
    end
    w_valid = 1'b0;
    w = '0;
  endtask

  task automatic recv_b(input resp_t resp, input logic [5:0] id, input string tag);
    b_ready = 1'b1;
    wait_sig(3, {tag, "_bvalid"});
    chk({tag, "_bresp"}, 128'(rsp.b.resp), 128'(resp));
    chk({tag, "_bid"}, 128'(rsp.b.id), 128'(id));
    tick();
    b_ready = 1'b0;
  endtask

  task automatic recv_r(input int n, input resp_t resp, input logic [5:0] id, input bit bp,
                        input string tag);
    for (int i = 0; i < n; i++) begin
      int k;
      k = bp ? int'($urandom_range(0, 2)) : 0;
      r_ready = (k == 0);
      wait_sig(4, {tag, "_rvalid"});
      for (int j = 0; j < k; j++) begin
        chk({tag, "_hold_data"}, rsp.r.data, ed[i]);
        chk({tag, "_hold_last"}, 128'(rsp.r.last), 128'(i == n - 1));
        tick();
      end
      r_ready = 1'b1;
      chk({tag, "_data"}, rsp.r.data, ed[i]);
      chk({tag, "_last"}, 128'(rsp.r.last), 128'(i == n - 1));
      chk({tag, "_resp"}, 128'(rsp.r.resp), 128'(resp));
      chk({tag, "_id"}, 128'(rsp.r.id), 128'(id));
      tick();
    end
    r_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_aw_ready"}, 128'(rsp.aw_ready), 128'(1));
    chk({tag, "_ar_ready"}, 128'(rsp.ar_ready), 128'(1));
    chk({tag, "_w_ready"}, 128'(rsp.w_ready), 128'(0));
    chk({tag, "_b_valid"}, 128'(rsp.b_valid), 128'(0));
    chk({tag, "_r_valid"}, 128'(rsp.r_valid), 128'(0));
    chk({tag, "_b_id"}, 128'(rsp.b.id), 128'(0));
    chk({tag, "_r_data"}, rsp.r.data, 128'(0));
  endtask

  initial begin
    aw = '0; w = '0; ar = '0;
    aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write four beats to 0x100 and read them back in order.
    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom};
      t1[i] = wd[i];
      ed[i] = wd[i];
    end
    send_aw(64'h100, 8'd3, BURST_INCR, 6'd5);
    send_w(4, 3, 16'hFFFF);
    recv_b(RESP_OKAY, 6'd5, "wr1");
    send_ar(64'h100, 8'd3, BURST_INCR, 6'd5);
    recv_r(4, RESP_OKAY, 6'd5, 1'b0, "rd1");

    // Partial strobe clears only the lower eight bytes.
    wd[0] = '1;
    send_aw(64'h0, 8'd0, BURST_INCR, 6'd1);
    send_w(1, 0, 16'hFFFF);
    recv_b(RESP_OKAY, 6'd1, "wr_ones");
    wd[0] = '0;
    send_aw(64'h0, 8'd0, BURST_INCR, 6'd2);
    send_w(1, 0, 16'h00FF);
    recv_b(RESP_OKAY, 6'd2, "wr_strb");
    ed[0] = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    send_ar(64'h0, 8'd0, BURST_INCR, 6'd3);
    recv_r(1, RESP_OKAY, 6'd3, 1'b0, "rd_strb");

    // FIXED burst: last beat wins.
    wd[0] = {4{32'hAAAA_0001}};
    wd[1] = {4{32'hBBBB_0002}};
    wd[2] = {4{32'hCCCC_0003}};
    send_aw(64'h40, 8'd2, BURST_FIXED, 6'd4);
    send_w(3, 2, 16'hFFFF);
    recv_b(RESP_OKAY, 6'd4, "wr_fixed");
    ed[0] = {4{32'hCCCC_0003}};
    send_ar(64'h40, 8'd0, BURST_INCR, 6'd4);
    recv_r(1, RESP_OKAY, 6'd4, 1'b0, "rd_fixed");

    // Write at word NumWords is rejected; word 0 (same index bits) unchanged.
    wd[0] = {4{32'h1234_5678}};
    send_aw(64'h4000, 8'd0, BURST_INCR, 6'd6);
    send_w(1, 0, 16'hFFFF);
    recv_b(RESP_SLVERR, 6'd6, "wr_oob");
    ed[0] = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    send_ar(64'h0, 8'd0, BURST_INCR, 6'd6);
    recv_r(1, RESP_OKAY, 6'd6, 1'b0, "rd_after_oob");

    // INCR burst whose second beat runs off the end drops both beats.
    wd[0] = {4{32'hD00D_0001}};
    send_aw(64'h3FF0, 8'd0, BURST_INCR, 6'd7);
    send_w(1, 0, 16'hFFFF);
    recv_b(RESP_OKAY, 6'd7, "wr_top");
    wd[0] = {4{32'hEEEE_0001}};
    wd[1] = {4{32'hEEEE_0002}};
    send_aw(64'h3FF0, 8'd1, BURST_INCR, 6'd7);
    send_w(2, 1, 16'hFFFF);
    recv_b(RESP_SLVERR, 6'd7, "wr_cross");
    ed[0] = {4{32'hD00D_0001}};
    send_ar(64'h3FF0, 8'd0, BURST_INCR, 6'd7);
    recv_r(1, RESP_OKAY, 6'd7, 1'b0, "rd_top");

    // WRAP read: two zero beats with SLVERR.
    ed[0] = '0;
    ed[1] = '0;
    send_ar(64'h100, 8'd1, BURST_WRAP, 6'd8);
    recv_r(2, RESP_SLVERR, 6'd8, 1'b0, "rd_wrap");

    // Early w_last: SLVERR, but the beats land.
    wd[0] = {4{32'h5555_0001}};
    wd[1] = {4{32'h5555_0002}};
    send_aw(64'h200, 8'd1, BURST_INCR, 6'd9);
    send_w(2, 0, 16'hFFFF);
    recv_b(RESP_SLVERR, 6'd9, "wr_wlast");
    ed[0] = wd[0];
    ed[1] = wd[1];
    send_ar(64'h200, 8'd1, BURST_INCR, 6'd9);
    recv_r(2, RESP_OKAY, 6'd9, 1'b0, "rd_wlast");

    // Concurrent write (B stalled 5 cycles) and read (random r_ready).
    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom};
      ed[i] = t1[i];
    end
    fork
      begin
        send_aw(64'h800, 8'd3, BURST_INCR, 6'd10);
        send_w(4, 3, 16'hFFFF);
        wait_sig(3, "bp_bvalid");
        for (int j = 0; j < 5; j++) begin
          chk("bp_b_valid", 128'(rsp.b_valid), 128'(1));
          chk("bp_b_resp", 128'(rsp.b.resp), 128'(RESP_OKAY));
          chk("bp_b_id", 128'(rsp.b.id), 128'(10));
          chk("bp_aw_ready_low", 128'(rsp.aw_ready), 128'(0));
          tick();
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        chk("bp_aw_ready_after_b", 128'(rsp.aw_ready), 128'(1));
      end
      begin
        send_ar(64'h100, 8'd3, BURST_INCR, 6'd5);
        recv_r(4, RESP_OKAY, 6'd5, 1'b1, "bp_rd");
      end
    join
    for (int i = 0; i < 4; i++) ed[i] = wd[i];
    send_ar(64'h800, 8'd3, BURST_INCR, 6'd11);
    recv_r(4, RESP_OKAY, 6'd11, 1'b0, "rd_bp_wr");

    // Reset after two of four beats; the two written beats remain.
    wd[0] = {4{32'h7777_0001}};
    wd[1] = {4{32'h7777_0002}};
    wd[2] = {4{32'h7777_0003}};
    wd[3] = {4{32'h7777_0004}};
    send_aw(64'h300, 8'd3, BURST_INCR, 6'd12);
    send_w(2, 3, 16'hFFFF);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    ed[0] = wd[0];
    ed[1] = wd[1];
    send_ar(64'h300, 8'd1, BURST_INCR, 6'd13);
    recv_r(2, RESP_OKAY, 6'd13, 1'b0, "rd_midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
